apb_req_arbiter: RTL and testbench

- Shares the single APB bridge between NREQ on-chip requesters, such as the filter-coefficient loader, the host/TB port and the debug port.
- Arbitrates round-robin, registers the winning command and drives the bridge's M-side (MTRANS/MWRITE/MSELx/MADDR/MWDATA).
- Tracks completion from PENABLE/PREADY and returns read data and a completion strobe to the winning requester.
- Allows one outstanding transfer at a time.

---
 rtl/apb_req_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB bridge among NREQ
// requesters, with one transfer outstanding at a time.
// Optional feature: define APB_ARB_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT_CYCLES and return an error response. A DRAIN state then absorbs
// the abandoned bus access.
module apb_req_arbiter #(
  parameter int NREQ           = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int COMP           = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*COMP-1:0]       req_sel,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_grant,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       MTRANS,
  output logic                       MWRITE,
  output logic [COMP-1:0]            MSELx,
  output logic [ADDR_WIDTH-1:0]      MADDR,
  output logic [DATA_WIDTH-1:0]      MWDATA,
  input  logic                       PENABLE,
  input  logic                       PREADY,
  input  logic [DATA_WIDTH-1:0]      MRDATA
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] rr, win, pick;
  logic [IW:0]   sum;
  logic          any;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Round-robin search: first asserted request at or above rr, wrapping.
  always_comb begin
    pick = rr;
    any  = 1'b0;
    sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any) begin
        sum = {1'b0, rr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        if (req_valid[sum[IW-1:0]]) begin
          any  = 1'b1;
          pick = sum[IW-1:0];
        end
      end
    end
  end

  // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle; constant 0 when disabled.
  assign tmo_hit = TMO_EN && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      rr        <= '0;
      win       <= '0;
      tmo_cnt   <= '0;
      req_grant <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      MTRANS    <= 1'b0;
      MWRITE    <= 1'b0;
      MSELx     <= '0;
      MADDR     <= '0;
      MWDATA    <= '0;
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      MTRANS    <= 1'b0;
      case (state)
        IDLE: if (any) begin
          // The command registers drive M* directly and stay frozen until
          // the next acceptance, so requester input changes cannot leak in.
          win       <= pick;
          rr        <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
          MWRITE    <= req_write[pick];
          MSELx     <= req_sel[pick*COMP +: COMP];
          MADDR     <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          MWDATA    <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          MTRANS    <= 1'b1;
          req_grant <= NREQ'(1) << pick;
          state     <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (PENABLE && PREADY) begin
            rsp_rdata <= MWRITE ? '0 : MRDATA;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << win;
            state     <= RESP;
          end else if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NREQ'(1) << win;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // A still-pending access after a timeout must finish before reuse.
        RESP:    state <= (TMO_EN && PENABLE && !PREADY) ? DRAIN : IDLE;
        DRAIN:   if (!PENABLE || PREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: scripted scenarios plus a
// randomized run checked against a pending-set / round-robin model.
// Scenarios and expectations follow the APB_ARB_TIMEOUT_EN build setting.
module tb_apb_req_arbiter;
  localparam int NREQ = 4, AW = 32, DW = 32, COMP = 4, TMO = 16;

  logic                 PCLK = 1'b0, PRESET = 1'b1;
  logic [NREQ-1:0]      req_valid = '0, req_write = '0;
  logic [NREQ*COMP-1:0] req_sel = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_grant, rsp_valid;
  logic [DW-1:0]        rsp_rdata, MWDATA;
  logic                 rsp_err, MTRANS, MWRITE;
  logic [COMP-1:0]      MSELx;
  logic [AW-1:0]        MADDR;
  logic                 PENABLE = 1'b0, PREADY = 1'b0;
  logic [DW-1:0]        MRDATA = '0;

  apb_req_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMP(COMP),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx),
    .MADDR(MADDR), .MWDATA(MWDATA), .PENABLE(PENABLE), .PREADY(PREADY),
    .MRDATA(MRDATA));

  always #5 PCLK = ~PCLK;

  int n_chk = 0, n_err = 0;
  int ph = 0, wleft = 0, wait_n = 0;
  logic hang = 1'b0;
  logic [DW-1:0] rd_val = '0;
  logic mtrans_s = 1'b0, rdy_s = 1'b0, rst_s = 1'b1;
  bit mon_on = 0, outst = 0;
  logic            c_write [NREQ];
  logic [COMP-1:0] c_sel   [NREQ];
  logic [AW-1:0]   c_addr  [NREQ];
  logic [DW-1:0]   c_wdata [NREQ];

  // Previous-cycle values seen by the bridge model and monitor.
  always @(negedge PCLK) begin
    mtrans_s <= MTRANS;
    rdy_s    <= PREADY;
    rst_s    <= PRESET;
  end

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  // APB bridge/completer model: SETUP after MTRANS, ACCESS with wait_n waits.
  initial forever begin
    tick();
    if (rst_s) ph = 0;
    else case (ph)
      0: if (mtrans_s) ph = 1;
      1: begin ph = 2; wleft = wait_n; end
      default: if (rdy_s) ph = 0; else if (wleft > 0) wleft--;
    endcase
    PENABLE = (ph == 2);
    PREADY  = (ph == 2) && (wleft == 0) && !hang;
    MRDATA  = PREADY ? rd_val : DW'($urandom);
  end

  // Protocol invariants: one-hot strobes, MTRANS only with a grant, one outstanding.
  initial forever begin
    tick();
    if (rst_s) outst = 0;
    else if (mon_on) begin
      n_chk++;
      if ($countones(req_grant) > 1 || $countones(rsp_valid) > 1) begin
        n_err++; $display("FAIL onehot: grant=%b rsp=%b", req_grant, rsp_valid);
      end
      n_chk++;
      if (MTRANS !== (req_grant != '0)) begin
        n_err++; $display("FAIL mtrans_only_issue: MTRANS=%b grant=%b", MTRANS, req_grant);
      end
      if (req_grant != '0) begin
        n_chk++;
        if (outst) begin n_err++; $display("FAIL two_outstanding: grant=%b while busy", req_grant); end
        outst = 1;
      end
      if (rsp_valid != '0) begin
        n_chk++;
        if (!outst) begin n_err++; $display("FAIL stray_rsp: rsp=%b with nothing outstanding", rsp_valid); end
        outst = 0;
      end
    end
  end

  task automatic set_cmd(input int i, input logic w, input logic [COMP-1:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_write[i] = w; c_sel[i] = s; c_addr[i] = a; c_wdata[i] = d;
    req_write[i] = w;
    req_sel[i*COMP +: COMP] = s;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom_range(0, 1)), COMP'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic wait_grant(input int lim, output bit got);
    got = 0;
    for (int w = 0; w < lim; w++) begin
      tick();
      if (req_grant != '0) begin got = 1; break; end
    end
  endtask

  task automatic wait_rsp(input int lim, output bit got, output int n);
    got = 0; n = 0;
    for (int w = 0; w < lim; w++) begin
      tick(); n++;
      if (rsp_valid != '0) begin got = 1; break; end
    end
  endtask

  task automatic test_reset();
    req_valid = '0; hang = 1'b0; wait_n = 0; PRESET = 1'b1;
    tick();
    n_chk++;
    if ({req_grant, rsp_valid, rsp_rdata, rsp_err, MTRANS, MWRITE, MSELx, MADDR, MWDATA} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b rsp=%b rdata=%h err=%b mtrans=%b maddr=%h, want all 0",
               req_grant, rsp_valid, rsp_rdata, rsp_err, MTRANS, MADDR);
    end
    PRESET = 1'b0;
    mon_on = 1;
  endtask

  task automatic test_single_write();
    test_reset();
    rd_val = 32'hFFFF_0001;
    set_cmd(0, 1'b1, 4'b0010, 32'h0000_0010, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) req_valid = '0;
      n_chk++;
      if (req_grant !== (k == 1 ? 4'b0001 : 4'b0000) || MTRANS !== (k == 1)) begin
        n_err++; $display("FAIL wr_grant t+%0d: grant=%b mtrans=%b", k, req_grant, MTRANS);
      end
      n_chk++;
      if (rsp_valid !== (k == 4 ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL wr_rsp_timing t+%0d: rsp=%b", k, rsp_valid);
      end
      if (k == 1) begin
        n_chk++;
        if ({MWRITE, MSELx, MADDR, MWDATA} !== {1'b1, 4'b0010, 32'h0000_0010, 32'hDEAD_BEEF}) begin
          n_err++; $display("FAIL wr_cmd: got w=%b sel=%b a=%h d=%h, want 1 0010 10 deadbeef",
                            MWRITE, MSELx, MADDR, MWDATA);
        end
      end
      if (k == 4) begin
        n_chk++;
        if (rsp_err !== 1'b0 || rsp_rdata !== '0) begin
          n_err++; $display("FAIL wr_rsp_data: err=%b rdata=%h want 0/0", rsp_err, rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_read_wait();
    test_reset();
    wait_n = 3; rd_val = 32'h1234_5678;
    set_cmd(1, 1'b0, 4'b0100, 32'h0000_0020, DW'($urandom));
    req_valid = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) req_valid = '0;
      n_chk++;
      if (rsp_valid !== (k == 7 ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL rd_rsp_timing t+%0d: rsp=%b", k, rsp_valid);
      end
      if (k == 7) begin
        n_chk++;
        if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
          n_err++; $display("FAIL rd_data: got %h err=%b want 12345678 err=0", rsp_rdata, rsp_err);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    bit got;
    test_reset();
    rand_cmd(0); rand_cmd(2);
    req_valid = 4'b0101;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) req_valid[0] = 1'b0;
      if (k == 7) req_valid[2] = 1'b0;
      n_chk++;
      if (req_grant !== (k == 1 ? 4'b0001 : (k == 6 ? 4'b0100 : 4'b0000))) begin
        n_err++; $display("FAIL sim_grant t+%0d: grant=%b", k, req_grant);
      end
      n_chk++;
      if (rsp_valid !== (k == 4 ? 4'b0001 : (k == 9 ? 4'b0100 : 4'b0000))) begin
        n_err++; $display("FAIL sim_rsp t+%0d: rsp=%b", k, rsp_valid);
      end
    end
    // Pointer should now sit at 3: of {1,3}, requester 3 wins.
    rand_cmd(1); rand_cmd(3);
    req_valid = 4'b1010;
    wait_grant(8, got);
    n_chk++;
    if (!got || req_grant !== 4'b1000) begin
      n_err++; $display("FAIL sim_rr_after: got=%0d grant=%b want 1000", got, req_grant);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    bit got; int n;
    logic [NREQ-1:0] exp_oh;
    test_reset();
    for (int i = 0; i < NREQ; i++) rand_cmd(i);
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      wait_n = $urandom_range(0, 2);
      wait_grant(20, got);
      exp_oh = '0; exp_oh[t % NREQ] = 1'b1;
      n_chk++;
      if (!got || req_grant !== exp_oh) begin
        n_err++; $display("FAIL rr_order #%0d: got=%0d grant=%b want %b", t, got, req_grant, exp_oh);
      end
      tick();
      rand_cmd(t % NREQ);
      wait_rsp(12, got, n);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    bit got, seen_rsp;
    test_reset();
    hang = 1'b1;
    rand_cmd(2);
    req_valid = 4'b0100;
    tick();
    n_chk++;
    if (req_grant !== 4'b0100) begin
      n_err++; $display("FAIL rst_pre_grant: grant=%b want 0100", req_grant);
    end
    tick();
    rand_cmd(1); rand_cmd(3);
    req_valid = 4'b1010;
    tick(); tick();
    PRESET = 1'b1;
    tick();
    n_chk++;
    if ({req_grant, rsp_valid, rsp_rdata, rsp_err, MTRANS, MWRITE, MSELx, MADDR, MWDATA} !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: grant=%b rsp=%b mtrans=%b maddr=%h want all 0",
                        req_grant, rsp_valid, MTRANS, MADDR);
    end
    PRESET = 1'b0; hang = 1'b0;
    got = 0; seen_rsp = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      if (rsp_valid != '0) seen_rsp = 1;
      if (req_grant != '0) got = 1;
    end
    n_chk++;
    if (seen_rsp) begin n_err++; $display("FAIL rst_no_rsp: got rsp after reset, want none"); end
    n_chk++;
    if (!got || req_grant !== 4'b0010) begin
      n_err++; $display("FAIL rst_regrant: got=%0d grant=%b want 0010", got, req_grant);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    bit got; int n, exp_g, exp_rr, j;
    logic [NREQ-1:0] pending, exp_oh;
    logic exp_w; logic [AW-1:0] exp_a;
    test_reset();
    exp_rr = 0; pending = '0;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pending[i] && $urandom_range(0, 1) == 1) begin rand_cmd(i); pending[i] = 1'b1; end
      if (pending == '0) begin j = $urandom_range(0, NREQ-1); rand_cmd(j); pending[j] = 1'b1; end
      req_valid = pending;
      wait_n = $urandom_range(0, 3);
      rd_val = DW'($urandom);
      exp_g = 0;
      for (int k = NREQ-1; k >= 0; k--)
        if (pending[(exp_rr + k) % NREQ]) exp_g = (exp_rr + k) % NREQ;
      exp_oh = '0; exp_oh[exp_g] = 1'b1;
      exp_w = c_write[exp_g]; exp_a = c_addr[exp_g];
      wait_grant(10, got);
      n_chk++;
      if (!got || req_grant !== exp_oh ||
          {MWRITE, MSELx, MADDR, MWDATA} !== {exp_w, c_sel[exp_g], exp_a, c_wdata[exp_g]}) begin
        n_err++;
        $display("FAIL rnd_grant #%0d: got=%0d grant=%b addr=%h want %b addr=%h",
                 t, got, req_grant, MADDR, exp_oh, exp_a);
        break;
      end
      exp_rr = (exp_g + 1) % NREQ;
      pending[exp_g] = 1'b0;
      tick();
      req_valid = pending;
      for (int i = 0; i < NREQ; i++) if (!pending[i]) rand_cmd(i);
      wait_rsp(12, got, n);
      n_chk++;
      if (!got || rsp_valid !== exp_oh || n + 1 != 3 + wait_n ||
          rsp_rdata !== (exp_w ? '0 : rd_val) || rsp_err !== 1'b0 || MADDR !== exp_a) begin
        n_err++;
        $display("FAIL rnd_rsp #%0d: rsp=%b lat=%0d rdata=%h err=%b maddr=%h want %b lat=%0d rdata=%h maddr=%h",
                 t, rsp_valid, n + 1, rsp_rdata, rsp_err, MADDR, exp_oh, 3 + wait_n,
                 exp_w ? '0 : rd_val, exp_a);
      end
    end
    req_valid = '0;
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit got; int n;
    test_reset();
    rd_val = 32'hA5A5_0F0F;
    set_cmd(3, 1'b0, 4'b1000, AW'($urandom), DW'($urandom));
    req_valid = 4'b1000;
    wait_grant(6, got);
    tick(); req_valid = '0;
    wait_rsp(10, got, n);
    n_chk++;
    if (!got || rsp_rdata !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL tmo_pre_read: got=%0d rdata=%h want a5a50f0f", got, rsp_rdata);
    end
    hang = 1'b1;
    set_cmd(0, 1'b0, 4'b0001, AW'($urandom), DW'($urandom));
    req_valid = 4'b0001;
    wait_grant(6, got);
    n_chk++;
    if (!got || req_grant !== 4'b0001) begin
      n_err++; $display("FAIL tmo_grant: got=%0d grant=%b want 0001", got, req_grant);
    end
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 1) begin set_cmd(1, 1'b0, 4'b0010, AW'($urandom), DW'($urandom)); req_valid = 4'b0010; end
      n_chk++;
      if (rsp_valid !== (k == TMO + 1 ? 4'b0001 : 4'b0000) || req_grant !== '0) begin
        n_err++; $display("FAIL tmo_timing t+%0d: rsp=%b grant=%b", k, rsp_valid, req_grant);
      end
      if (k == TMO + 1) begin
        n_chk++;
        if (rsp_err !== 1'b1 || rsp_rdata !== '0) begin
          n_err++; $display("FAIL tmo_resp: err=%b rdata=%h want 1/0", rsp_err, rsp_rdata);
        end
      end
    end
    rd_val = 32'h0BAD_F00D;
    hang = 1'b0;
    wait_grant(8, got);
    n_chk++;
    if (!got || req_grant !== 4'b0010) begin
      n_err++; $display("FAIL tmo_drain_exit: got=%0d grant=%b want 0010", got, req_grant);
    end
    tick(); req_valid = '0;
    wait_rsp(10, got, n);
    n_chk++;
    if (!got || rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL tmo_after: rsp=%b err=%b rdata=%h want 0010/0/0badf00d",
                        rsp_valid, rsp_err, rsp_rdata);
    end
  endtask
`else
  task automatic test_no_timeout();
    bit got, seen; int n;
    test_reset();
    hang = 1'b1;
    rand_cmd(0);
    req_valid = 4'b0001;
    wait_grant(6, got);
    tick(); req_valid = '0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rsp_valid != '0 || rsp_err !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen) begin n_err++; $display("FAIL no_tmo_wait: response during unbounded WAIT, want none"); end
    hang = 1'b0;
    wait_rsp(6, got, n);
    n_chk++;
    if (!got || rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL no_tmo_finish: got=%0d rsp=%b err=%b want 0001/0", got, rsp_valid, rsp_err);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, '0, '0, '0);
    tick();
    test_reset();
    test_single_write();
    test_read_wait();
    test_simultaneous();
    test_round_robin();
    test_reset_mid_wait();
    test_random();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
